// File: rtl/toggle_div_bank.sv
// rtl/toggle_div_bank.sv - bank of independent programmable-divide toggle outputs with tick strobes
module toggle_div_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int IDX_W    = 2
) (
  input  logic                clka,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                clr,
  input  logic                load,
  input  logic [IDX_W-1:0]    load_ch,
  input  logic [DIV_W-1:0]    load_div,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);

  logic [DIV_W-1:0]    div_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] load_sel;

  // Decode the divisor write; indices beyond the last channel select nothing.
  always_comb begin
    load_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load && (32'(load_ch) == i)) begin
        load_sel[i] = 1'b1;
      end
    end
  end

  // Per-channel divisor, counter, toggle output and tick; clear beats load beats counting.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      tick <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // The divisor write lands even alongside a clear.
        if (load_sel[i]) begin
          div_q[i] <= load_div;
        end

        if (clr) begin
          cnt_q[i] <= '0;
          out[i]   <= 1'b0;
          tick[i]  <= 1'b0;
        end else if (load_sel[i]) begin
          // Restart the period with the new divisor; a coincident terminal count is dropped.
          cnt_q[i] <= '0;
          tick[i]  <= 1'b0;
        end else if (en[i]) begin
          if (cnt_q[i] == div_q[i]) begin
            cnt_q[i] <= '0;
            out[i]   <= ~out[i];
            tick[i]  <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
            tick[i]  <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_div_bank.sv
// tb/tb_toggle_div_bank.sv - randomized and directed self-checking bench for toggle_div_bank
module tb_toggle_div_bank;

  localparam int CH    = 4;
  localparam int DIV_W = 8;
  localparam int IDX_W = 2;

  logic             clka;
  logic             reset;
  logic [CH-1:0]    en;
  logic             clr;
  logic             load;
  logic [IDX_W-1:0] load_ch;
  logic [DIV_W-1:0] load_div;
  logic [CH-1:0]    out;
  logic [CH-1:0]    tick;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  // Reference: each channel remembers how many enabled cycles have elapsed
  // since its period last restarted; reaching div+1 of them flips the output.
  int          m_div     [CH];
  int          m_elapsed [CH];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_tick;

  toggle_div_bank #(.CHANNELS(CH), .DIV_W(DIV_W), .IDX_W(IDX_W)) dut (
    .clka     (clka),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .out      (out),
    .tick     (tick)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model update.
  always @(posedge clka or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        m_div[i]     <= 0;
        m_elapsed[i] <= 0;
      end
      m_out  <= '0;
      m_tick <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        automatic bit sel = load && (int'(load_ch) == i);
        automatic int e   = m_elapsed[i] + 1;
        if (sel) m_div[i] <= int'(load_div);
        if (clr) begin
          m_elapsed[i] <= 0;
          m_out[i]     <= 1'b0;
          m_tick[i]    <= 1'b0;
        end else if (sel) begin
          m_elapsed[i] <= 0;
          m_tick[i]    <= 1'b0;
        end else if (en[i]) begin
          if (e == m_div[i] + 1) begin
            m_elapsed[i] <= 0;
            m_out[i]     <= ~m_out[i];
            m_tick[i]    <= 1'b1;
          end else begin
            m_elapsed[i] <= e;
            m_tick[i]    <= 1'b0;
          end
        end else begin
          m_tick[i] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clka) begin
    if (chk_on) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  task automatic cyc();
    @(negedge clka);
    #2;
  endtask

  task automatic do_load(input int ch, input int d);
    load = 1'b1; load_ch = IDX_W'(ch); load_div = DIV_W'(d);
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = '0; clr = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    #1 reset = 1'b0;
    chk_on = 1;
    cyc(); cyc();
    check("reset_out", 32'(out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);

    // Channel 0 with cleared divisor toggles every enabled cycle.
    reset = 1'b1; en = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("t1_out0", 32'(out[0]), 32'(k % 2));
      check("t1_tick0", 32'(tick[0]), 32'd1);
      check("t1_out_hi", 32'(out[3:1] | tick[3:1]), 32'd0);
    end

    // Channel 1 divide-by-4.
    en = '0;
    do_load(1, 3);
    en = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("t2_out1", 32'(out[1]), 32'((k / 4) % 2));
      check("t2_tick1", 32'(tick[1]), 32'(k % 4 == 0));
      check("t2_out0", 32'(out[0]), 32'd0);
    end

    // Channel 2 paused for 3 cycles at cnt=2 toggles 3 cycles late.
    en = '0;
    do_load(2, 5);
    for (int k = 1; k <= 9; k++) begin
      en = (k >= 3 && k <= 5) ? 4'b0000 : 4'b0100;
      cyc();
      check("t3_out2", 32'(out[2]), 32'(k >= 9));
      check("t3_tick2", 32'(tick[2]), 32'(k == 9));
    end

    // Load on channel 0 terminal-count cycle suppresses that toggle.
    en = '0;
    do_load(0, 2);
    en = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      load = (k == 6); load_ch = 2'd0; load_div = 8'd1;
      cyc();
      check("t4_out0", 32'(out[0]), 32'((k >= 3 && k <= 7) || k == 10));
      check("t4_tick0", 32'(tick[0]), 32'(k == 3 || k == 8 || k == 10));
    end
    load = 1'b0;

    // Clear together with a load on channel 3.
    en = 4'b1111; clr = 1'b1; load = 1'b1; load_ch = 2'd3; load_div = 8'd7;
    cyc();
    clr = 1'b0; load = 1'b0;
    check("t5_clr_out", 32'(out), 32'd0);
    check("t5_clr_tick", 32'(tick), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("t5_out3", 32'(out[3]), 32'(k == 8));
      check("t5_tick3", 32'(tick[3]), 32'(k == 8));
    end

    // Build out=1010, then reset asynchronously between edges.
    en = '0;
    do_load(3, 3);
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 4'b1010;
    repeat (4) cyc();
    en = '0;
    cyc();
    check("t6_pre_out", 32'(out), 32'hA);
    #1 reset = 1'b0;
    #1;
    check("t6_async_out", 32'(out), 32'd0);
    check("t6_async_tick", 32'(tick), 32'd0);
    cyc(); cyc();
    reset = 1'b1; en = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t6_out1", 32'(out[1]), 32'(k % 2));
      check("t6_tick1", 32'(tick[1]), 32'd1);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      en   = CH'($urandom);
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_ch = IDX_W'($urandom);
      load_div = ($urandom_range(0, 15) == 0) ? 8'hFF : DIV_W'($urandom_range(0, 6));
      cyc();
    end
    clr = 1'b0; load = 1'b0;

    // Maximum period on channel 0: 256 enabled cycles per toggle.
    en = '0;
    do_load(0, 255);
    clr = 1'b1; cyc(); clr = 1'b0;
    en = 4'b0001;
    for (int k = 1; k <= 256; k++) begin
      cyc();
      if (k == 255 || k == 256) begin
        check("t7_max_out0", 32'(out[0]), 32'(k == 256));
      end
    end

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_div_bank.md
Name: toggle_div_bank

Overview:
- Parametrised, multi-channel successor to the single toggle flop: CHANNELS independent toggle outputs.
- Each channel toggles once every (div+1) enabled clka cycles, with a runtime-programmable divide ratio.
- Adds per-channel enable, a one-cycle toggle strobe, a divisor load port and a synchronous clear.
- Serves as a programmable clock-enable and divided-strobe source for test harnesses and peripheral blocks.

Parameters:
- CHANNELS, 4, number of independent toggle channels (1..16).
- DIV_W, 8, width of each channel's divisor register and cycle counter.
- IDX_W, 2, width of load_ch; constraint: 2**IDX_W >= CHANNELS.

Ports:
- clka  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset: 0 resets the block, 1 lets it run.
- en  input  CHANNELS  per-channel count enable; bit i gates channel i.
- clr  input  1  synchronous clear of all counters and outputs.
- load  input  1  single-cycle divisor write strobe.
- load_ch  input  IDX_W  channel index for the divisor write.
- load_div  input  DIV_W  divisor value for the write.
- out  output  CHANNELS  toggle outputs, registered.
- tick  output  CHANNELS  one-cycle pulse, high in the cycle out[i] changes (registered alongside out).

Behaviour:
- Clock and reset: one clock, clka. reset is asynchronous and active-low. While reset=0: out=0, tick=0, all counters cnt[i]=0, all divisor registers div[i]=0. Deassertion takes effect at the next rising edge of clka.
- Per-channel state: div[i] (DIV_W bits) and cnt[i] (DIV_W bits).
- Normal count, per rising edge, channel i with en[i]=1:
  - cnt[i] != div[i]: cnt[i] <= cnt[i]+1; tick[i] <= 0.
  - cnt[i] == div[i]: terminal count; out[i] <= ~out[i], tick[i] <= 1, cnt[i] <= 0.
  - Resulting period: out[i] toggles every div[i]+1 enabled cycles.
  - div=0 toggles every enabled cycle, matching the original block.
- en[i]=0: cnt[i] and out[i] hold; tick[i] <= 0. Counting resumes from the held cnt when en returns high.
- Load, load=1 with load_ch < CHANNELS:
  - div[load_ch] <= load_div; cnt[load_ch] <= 0; out[load_ch] holds; tick[load_ch] <= 0.
  - Load suppresses a terminal count on the same channel in the same cycle (no toggle).
  - Other channels are unaffected.
- Load with load_ch >= CHANNELS: ignored, no state changes.
- Clear, clr=1: all cnt <= 0, out <= 0, tick <= 0; div registers are retained. clr overrides counting and toggling on every channel.
- clr and load in the same cycle: the clear is applied and the divisor write still lands. Counting begins next cycle with the new divisor.
- Divisor changed mid-count: the new value takes effect immediately because the load also restarts cnt. There is no partial-period carry-over.
- Wrap-around: cnt never exceeds div[i], so no overflow. div = 2**DIV_W-1 gives the maximum period, 2**DIV_W cycles per toggle.
- tick is never high for more than one consecutive cycle, except when div[i]=0 with en[i] held high (tick high continuously, out toggling every cycle).
- Reset mid-operation: immediate asynchronous return to the reset state; the divisor values written before reset are lost.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset then release, en=4'b0001, no load, 6 cycles -> out[0] sequence 1,0,1,0,1,0; tick[0]=1 every cycle; out[3:1]=0, tick[3:1]=0.
- Load ch1 with div=3, then en[1]=1 for 12 cycles -> out[1] toggles on cycles 4, 8, 12; tick[1] pulses exactly on those cycles; out[0] unchanged.
- Channel 2 with div=5 counting, en[2] dropped for 3 cycles at cnt=2 -> out[2] holds; the toggle arrives exactly 3 cycles later than without the pause.
- Load on the terminal-count cycle of ch0 (div=2, new load_div=1) -> no toggle that cycle; next toggle 2 cycles later, then every 2 cycles.
- clr with load ch3 (div=7) in the same cycle, all channels high -> all out=0, tick=0 next cycle; ch3 first toggles 8 enabled cycles after clr; load_ch=3 accepted.
- Assert reset=0 asynchronously between edges while out=4'b1010 -> out=0 and tick=0 immediately, before the next edge; after release, a ch1 with div=0 toggles every enabled cycle (divisor cleared).
